// File: rtl/alu_issue_scheduler_if.sv
// ALU operation encoding plus the two-requester issue bus and the result bus.
// The scheduler is the slave side; requesters and the result consumer sit on the master side.
typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
    ALU_BEQ, ALU_BNE, ALU_JAL, ALU_JALR
} alu_operation_t;

interface alu_issue_scheduler_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) ();
   logic [1:0]                  req_valid_i;
   logic [1:0]                  req_ready_o;
   logic [1:0][XLEN-1:0]        req_operand_A_i;
   logic [1:0][XLEN-1:0]        req_operand_B_i;
   logic [1:0][XLEN-1:0]        req_instr_addr_i;
   alu_operation_t [1:0]        req_operation_i;
   logic [1:0]                  req_is_compressed_i;
   logic [1:0][TAG_W-1:0]       req_tag_i;

   logic                        res_valid_o;
   logic                        res_ready_i;
   logic [XLEN-1:0]             res_result_o;
   logic [TAG_W-1:0]            res_tag_o;
   logic                        res_source_o;
   logic                        res_is_branch_o;
   logic                        res_branch_taken_o;

   modport slave (
      input  req_valid_i, req_operand_A_i, req_operand_B_i, req_instr_addr_i,
             req_operation_i, req_is_compressed_i, req_tag_i, res_ready_i,
      output req_ready_o, res_valid_o, res_result_o, res_tag_o, res_source_o,
             res_is_branch_o, res_branch_taken_o
   );

   modport master (
      output req_valid_i, req_operand_A_i, req_operand_B_i, req_instr_addr_i,
             req_operation_i, req_is_compressed_i, req_tag_i, res_ready_i,
      input  req_ready_o, res_valid_o, res_result_o, res_tag_o, res_source_o,
             res_is_branch_o, res_branch_taken_o
   );
endinterface

// File: rtl/alu_issue_scheduler.sv
// Round-robin issue of two requesters onto one shared combinational ALU; result registered 1 cycle after accept.
// Backpressure: no grant while the result register is full and unconsumed, during a redirect wait, or on flush.
module alu_issue_scheduler #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 flush_i,
   input  logic                 redirect_ack_i,
   alu_issue_scheduler_if.slave bus,

   output logic [XLEN-1:0]      alu_operand_A_o,
   output logic [XLEN-1:0]      alu_operand_B_o,
   output logic [XLEN-1:0]      alu_instr_addr_o,
   output alu_operation_t       alu_operation_o,
   output logic                 alu_is_compressed_jump_o,
   output logic                 alu_data_valid_o,

   input  logic [XLEN-1:0]      alu_result_i,
   input  logic                 alu_branch_taken_i,
   input  logic                 alu_is_branch_i,
   input  logic                 alu_data_valid_i,

   output logic                 wait_redirect_o,
   output logic [15:0]          stall_cycles_o
);

   typedef enum logic {ISSUE, WAIT_REDIRECT} state_t;

   state_t            state_q, state_d;
   logic              last_grant_q, last_grant_d;
   logic              res_valid_q, res_valid_d;
   logic [XLEN-1:0]   res_result_q, res_result_d;
   logic [TAG_W-1:0]  res_tag_q, res_tag_d;
   logic              res_source_q, res_source_d;
   logic              res_is_branch_q, res_is_branch_d;
   logic              res_branch_taken_q, res_branch_taken_d;
   logic [15:0]       stall_q, stall_d;

   logic              can_issue;
   logic              grant_vld;
   logic              grant_idx;
   logic              accept;

   // With no grant, grant_idx rests on last_grant so the ALU sees that port's payload.
   always_comb begin
      can_issue = (state_q == ISSUE) && !flush_i && (!res_valid_q || bus.res_ready_i);
      grant_vld = 1'b0;
      grant_idx = last_grant_q;
      if (can_issue) begin
         if (&bus.req_valid_i) begin
            grant_vld = 1'b1;
            grant_idx = ~last_grant_q;
         end else if (bus.req_valid_i[0]) begin
            grant_vld = 1'b1;
            grant_idx = 1'b0;
         end else if (bus.req_valid_i[1]) begin
            grant_vld = 1'b1;
            grant_idx = 1'b1;
         end
      end
   end

   assign accept          = grant_vld & bus.req_valid_i[grant_idx];
   assign bus.req_ready_o = {grant_vld & grant_idx, grant_vld & ~grant_idx};

   assign alu_operand_A_o          = bus.req_operand_A_i[grant_idx];
   assign alu_operand_B_o          = bus.req_operand_B_i[grant_idx];
   assign alu_instr_addr_o         = bus.req_instr_addr_i[grant_idx];
   assign alu_operation_o          = bus.req_operation_i[grant_idx];
   assign alu_is_compressed_jump_o = bus.req_is_compressed_i[grant_idx];
   assign alu_data_valid_o         = accept;

   always_comb begin
      state_d            = state_q;
      last_grant_d       = last_grant_q;
      res_valid_d        = res_valid_q;
      res_result_d       = res_result_q;
      res_tag_d          = res_tag_q;
      res_source_d       = res_source_q;
      res_is_branch_d    = res_is_branch_q;
      res_branch_taken_d = res_branch_taken_q;
      stall_d            = stall_q;

      if (flush_i) begin
         res_valid_d = 1'b0;
         state_d     = ISSUE;
      end else begin
         if (state_q == WAIT_REDIRECT && redirect_ack_i) begin
            state_d = ISSUE;
         end
         if (accept) begin
            res_valid_d        = 1'b1;
            res_result_d       = alu_result_i;
            res_tag_d          = bus.req_tag_i[grant_idx];
            res_source_d       = grant_idx;
            res_is_branch_d    = alu_is_branch_i;
            res_branch_taken_d = alu_branch_taken_i;
            last_grant_d       = grant_idx;
            if (alu_is_branch_i && alu_branch_taken_i) begin
               state_d = WAIT_REDIRECT;
            end
         end else if (bus.res_ready_i) begin
            res_valid_d = 1'b0;
         end
      end

      // Contention counter keeps counting through flushes; it only saturates.
      if ((|bus.req_valid_i) && !accept && (stall_q != 16'hFFFF)) begin
         stall_d = stall_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q            <= ISSUE;
         last_grant_q       <= 1'b1;
         res_valid_q        <= 1'b0;
         res_result_q       <= '0;
         res_tag_q          <= '0;
         res_source_q       <= 1'b0;
         res_is_branch_q    <= 1'b0;
         res_branch_taken_q <= 1'b0;
         stall_q            <= '0;
      end else begin
         state_q            <= state_d;
         last_grant_q       <= last_grant_d;
         res_valid_q        <= res_valid_d;
         res_result_q       <= res_result_d;
         res_tag_q          <= res_tag_d;
         res_source_q       <= res_source_d;
         res_is_branch_q    <= res_is_branch_d;
         res_branch_taken_q <= res_branch_taken_d;
         stall_q            <= stall_d;
      end
   end

   assign bus.res_valid_o        = res_valid_q;
   assign bus.res_result_o       = res_result_q;
   assign bus.res_tag_o          = res_tag_q;
   assign bus.res_source_o       = res_source_q;
   assign bus.res_is_branch_o    = res_is_branch_q;
   assign bus.res_branch_taken_o = res_branch_taken_q;
   assign wait_redirect_o        = (state_q == WAIT_REDIRECT);
   assign stall_cycles_o         = stall_q;

   // The ALU echoes our valid; it never steers control.
   a_alu_valid_echo: assert property (@(posedge clk_i) disable iff (!rst_n_i)
      alu_data_valid_i == alu_data_valid_o);

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// Testbench for alu_issue_scheduler: directed scenarios plus a randomized run against a behavioural model.
module tb_alu_issue_scheduler;

   typedef struct packed {
      logic [31:0] res;
      logic        br;
      logic        tk;
   } alu_rsp_t;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        redirect_ack_i = 1'b0;
   logic [31:0] alu_operand_A_o, alu_operand_B_o, alu_instr_addr_o;
   alu_operation_t alu_operation_o;
   logic        alu_is_compressed_jump_o, alu_data_valid_o;
   logic [31:0] alu_result_i;
   logic        alu_branch_taken_i, alu_is_branch_i, alu_data_valid_i;
   logic        wait_redirect_o;
   logic [15:0] stall_cycles_o;
   alu_rsp_t    alu_rsp;

   int n_checks = 0;
   int n_errors = 0;

   // Behavioural model state
   int          m_last;
   bit          m_wait;
   bit          m_rv;
   logic [31:0] m_res;
   logic [3:0]  m_tag;
   int          m_src;
   bit          m_br, m_tk;
   int          m_stall;

   alu_issue_scheduler_if bus ();

   alu_issue_scheduler dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .flush_i(flush_i), .redirect_ack_i(redirect_ack_i),
      .bus(bus),
      .alu_operand_A_o(alu_operand_A_o), .alu_operand_B_o(alu_operand_B_o),
      .alu_instr_addr_o(alu_instr_addr_o), .alu_operation_o(alu_operation_o),
      .alu_is_compressed_jump_o(alu_is_compressed_jump_o), .alu_data_valid_o(alu_data_valid_o),
      .alu_result_i(alu_result_i), .alu_branch_taken_i(alu_branch_taken_i),
      .alu_is_branch_i(alu_is_branch_i), .alu_data_valid_i(alu_data_valid_i),
      .wait_redirect_o(wait_redirect_o), .stall_cycles_o(stall_cycles_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic alu_rsp_t ref_alu(input alu_operation_t op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] pc, input logic c);
      alu_rsp_t r;
      logic [31:0] link;
      r = '0;
      link = pc + (c ? 32'd2 : 32'd4);
      case (op)
         ALU_ADD:  r.res = a + b;
         ALU_SUB:  r.res = a - b;
         ALU_AND:  r.res = a & b;
         ALU_OR:   r.res = a | b;
         ALU_XOR:  r.res = a ^ b;
         ALU_SLL:  r.res = a << b[4:0];
         ALU_BEQ:  begin r.res = link; r.br = 1'b1; r.tk = (a == b); end
         ALU_BNE:  begin r.res = link; r.br = 1'b1; r.tk = (a != b); end
         ALU_JAL, ALU_JALR: begin r.res = link; r.br = 1'b1; r.tk = 1'b1; end
         default:  r.res = '0;
      endcase
      return r;
   endfunction

   // The ALU itself is modelled in the bench.
   assign alu_rsp            = ref_alu(alu_operation_o, alu_operand_A_o, alu_operand_B_o,
                                       alu_instr_addr_o, alu_is_compressed_jump_o);
   assign alu_result_i       = alu_rsp.res;
   assign alu_is_branch_i    = alu_rsp.br;
   assign alu_branch_taken_i = alu_rsp.tk;
   assign alu_data_valid_i   = alu_data_valid_o;

   task automatic settle(); @(negedge clk_i); endtask
   task automatic step();   @(posedge clk_i); #1; endtask

   task automatic set_req(input int i, input logic v, input alu_operation_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] pc, input logic c, input logic [3:0] tag);
      bus.req_valid_i[i]         = v;
      bus.req_operation_i[i]     = op;
      bus.req_operand_A_i[i]     = a;
      bus.req_operand_B_i[i]     = b;
      bus.req_instr_addr_i[i]    = pc;
      bus.req_is_compressed_i[i] = c;
      bus.req_tag_i[i]           = tag;
   endtask

   task automatic idle_all();
      set_req(0, 1'b0, ALU_ADD, 0, 0, 0, 1'b0, 0);
      set_req(1, 1'b0, ALU_ADD, 0, 0, 0, 1'b0, 0);
      flush_i = 1'b0;
      redirect_ack_i = 1'b0;
      bus.res_ready_i = 1'b1;
   endtask

   task automatic model_reset();
      m_last = 1; m_wait = 0; m_rv = 0; m_res = 0; m_tag = 0;
      m_src = 0; m_br = 0; m_tk = 0; m_stall = 0;
   endtask

   task automatic do_reset();
      rst_n_i = 1'b0;
      idle_all();
      model_reset();
      repeat (2) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
   endtask

   // Which port the rules say should be granted this cycle (-1: none).
   function automatic int model_grant();
      if (m_wait || flush_i || (m_rv && !bus.res_ready_i)) return -1;
      if (bus.req_valid_i == 2'b11) return 1 - m_last;
      if (bus.req_valid_i[0]) return 0;
      if (bus.req_valid_i[1]) return 1;
      return -1;
   endfunction

   task automatic model_update(input int g);
      alu_rsp_t r;
      if ((bus.req_valid_i != 0) && g < 0 && m_stall < 65535) m_stall++;
      if (flush_i) begin
         m_rv = 0; m_wait = 0;
      end else begin
         if (m_wait && redirect_ack_i) m_wait = 0;
         if (g >= 0) begin
            r = ref_alu(bus.req_operation_i[g], bus.req_operand_A_i[g], bus.req_operand_B_i[g],
                        bus.req_instr_addr_i[g], bus.req_is_compressed_i[g]);
            m_rv = 1; m_res = r.res; m_tag = bus.req_tag_i[g]; m_src = g;
            m_br = r.br; m_tk = r.tk; m_last = g;
            if (r.br && r.tk) m_wait = 1;
         end else if (bus.res_ready_i) begin
            m_rv = 0;
         end
      end
   endtask

   task automatic test_reset();
      do_reset();
      settle();
      n_checks++; if (bus.res_valid_o !== 1'b0) begin n_errors++; $display("FAIL reset_res_valid got=%b exp=0", bus.res_valid_o); end
      n_checks++; if (bus.res_result_o !== 32'd0) begin n_errors++; $display("FAIL reset_res_result got=%h exp=0", bus.res_result_o); end
      n_checks++; if (wait_redirect_o !== 1'b0) begin n_errors++; $display("FAIL reset_wait got=%b exp=0", wait_redirect_o); end
      n_checks++; if (stall_cycles_o !== 16'd0) begin n_errors++; $display("FAIL reset_stall got=%0d exp=0", stall_cycles_o); end
      n_checks++; if (bus.req_ready_o !== 2'b00) begin n_errors++; $display("FAIL reset_ready_idle got=%b exp=00", bus.req_ready_o); end
   endtask

   task automatic test_round_robin();
      int exp_g;
      do_reset();
      set_req(0, 1'b1, ALU_ADD, 1, 2, 0, 1'b0, 4'd3);
      set_req(1, 1'b1, ALU_ADD, 10, 20, 0, 1'b0, 4'd5);
      exp_g = 0;
      for (int k = 0; k < 6; k++) begin
         settle();
         n_checks++; if (bus.req_ready_o !== (exp_g == 1 ? 2'b10 : 2'b01)) begin n_errors++; $display("FAIL rr_ready cyc=%0d got=%b exp_port=%0d", k, bus.req_ready_o, exp_g); end
         n_checks++; if (bus.res_valid_o !== (k > 0)) begin n_errors++; $display("FAIL rr_res_valid cyc=%0d got=%b exp=%0d", k, bus.res_valid_o, k > 0); end
         if (k > 0) begin
            n_checks++; if (bus.res_result_o !== (exp_g == 1 ? 32'd3 : 32'd30)) begin n_errors++; $display("FAIL rr_result cyc=%0d got=%0d", k, bus.res_result_o); end
            n_checks++; if (bus.res_source_o !== (exp_g == 0)) begin n_errors++; $display("FAIL rr_source cyc=%0d got=%b exp=%0d", k, bus.res_source_o, 1 - exp_g); end
         end
         step();
         exp_g = 1 - exp_g;
      end
   endtask

   task automatic test_hold();
      do_reset();
      bus.res_ready_i = 1'b0;
      set_req(0, 1'b1, ALU_ADD, 5, 7, 0, 1'b0, 4'd1);
      settle();
      n_checks++; if (bus.req_ready_o !== 2'b01) begin n_errors++; $display("FAIL hold_first_ready got=%b exp=01", bus.req_ready_o); end
      step();
      set_req(0, 1'b0, ALU_ADD, 0, 0, 0, 1'b0, 0);
      set_req(1, 1'b1, ALU_SUB, 50, 8, 0, 1'b0, 4'd9);
      for (int k = 0; k < 3; k++) begin
         settle();
         n_checks++; if (bus.req_ready_o !== 2'b00) begin n_errors++; $display("FAIL hold_stalled_ready cyc=%0d got=%b exp=00", k, bus.req_ready_o); end
         n_checks++; if (bus.res_result_o !== 32'd12 || bus.res_valid_o !== 1'b1) begin n_errors++; $display("FAIL hold_result cyc=%0d got=%0d/v%b exp=12/v1", k, bus.res_result_o, bus.res_valid_o); end
         step();
      end
      bus.res_ready_i = 1'b1;
      settle();
      n_checks++; if (stall_cycles_o !== 16'd3) begin n_errors++; $display("FAIL hold_stall_count got=%0d exp=3", stall_cycles_o); end
      n_checks++; if (bus.req_ready_o !== 2'b10) begin n_errors++; $display("FAIL hold_resume_ready got=%b exp=10", bus.req_ready_o); end
      step();
      settle();
      n_checks++; if (bus.res_result_o !== 32'd42 || bus.res_source_o !== 1'b1 || bus.res_tag_o !== 4'd9) begin n_errors++; $display("FAIL hold_next_result got=%0d src=%b tag=%0d exp=42 src=1 tag=9", bus.res_result_o, bus.res_source_o, bus.res_tag_o); end
   endtask

   task automatic test_branch();
      do_reset();
      set_req(1, 1'b1, ALU_BEQ, 9, 9, 32'h100, 1'b0, 4'd7);
      settle();
      n_checks++; if (bus.req_ready_o !== 2'b10) begin n_errors++; $display("FAIL br_ready got=%b exp=10", bus.req_ready_o); end
      step();
      set_req(1, 1'b0, ALU_ADD, 0, 0, 0, 1'b0, 0);
      set_req(0, 1'b1, ALU_ADD, 1, 1, 0, 1'b0, 4'd2);
      settle();
      n_checks++; if (bus.res_branch_taken_o !== 1'b1 || bus.res_is_branch_o !== 1'b1) begin n_errors++; $display("FAIL br_taken got=%b/%b exp=1/1", bus.res_is_branch_o, bus.res_branch_taken_o); end
      n_checks++; if (bus.res_result_o !== 32'h104 || bus.res_tag_o !== 4'd7) begin n_errors++; $display("FAIL br_link got=%h tag=%0d exp=104 tag=7", bus.res_result_o, bus.res_tag_o); end
      n_checks++; if (wait_redirect_o !== 1'b1) begin n_errors++; $display("FAIL br_wait got=%b exp=1", wait_redirect_o); end
      for (int k = 0; k < 3; k++) begin
         if (k > 0) settle();
         n_checks++; if (bus.req_ready_o !== 2'b00) begin n_errors++; $display("FAIL br_no_grant cyc=%0d got=%b exp=00", k, bus.req_ready_o); end
         step();
      end
      redirect_ack_i = 1'b1;
      settle();
      n_checks++; if (bus.req_ready_o !== 2'b00) begin n_errors++; $display("FAIL br_ack_cycle_grant got=%b exp=00", bus.req_ready_o); end
      step();
      redirect_ack_i = 1'b0;
      settle();
      n_checks++; if (wait_redirect_o !== 1'b0 || bus.req_ready_o !== 2'b01) begin n_errors++; $display("FAIL br_resume got=w%b/%b exp=w0/01", wait_redirect_o, bus.req_ready_o); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.res_ready_i = 1'b0;
      set_req(1, 1'b1, ALU_JAL, 0, 0, 32'h200, 1'b1, 4'd4);
      step();
      set_req(1, 1'b0, ALU_ADD, 0, 0, 0, 1'b0, 0);
      settle();
      n_checks++; if (bus.res_valid_o !== 1'b1 || wait_redirect_o !== 1'b1 || bus.res_result_o !== 32'h202) begin n_errors++; $display("FAIL fl_setup got=v%b w%b %h exp=v1 w1 202", bus.res_valid_o, wait_redirect_o, bus.res_result_o); end
      step();
      flush_i = 1'b1;
      redirect_ack_i = 1'b1;
      bus.res_ready_i = 1'b1;
      set_req(0, 1'b1, ALU_ADD, 3, 4, 0, 1'b0, 4'd1);
      set_req(1, 1'b1, ALU_ADD, 5, 6, 0, 1'b0, 4'd2);
      settle();
      n_checks++; if (bus.req_ready_o !== 2'b00 || alu_data_valid_o !== 1'b0) begin n_errors++; $display("FAIL fl_no_grant got=%b dv=%b exp=00 dv=0", bus.req_ready_o, alu_data_valid_o); end
      step();
      flush_i = 1'b0;
      redirect_ack_i = 1'b0;
      settle();
      n_checks++; if (bus.res_valid_o !== 1'b0 || wait_redirect_o !== 1'b0) begin n_errors++; $display("FAIL fl_cleared got=v%b w%b exp=v0 w0", bus.res_valid_o, wait_redirect_o); end
      n_checks++; if (bus.req_ready_o !== 2'b01) begin n_errors++; $display("FAIL fl_last_grant_kept got=%b exp=01", bus.req_ready_o); end
   endtask

   task automatic test_saturate();
      do_reset();
      bus.res_ready_i = 1'b0;
      set_req(0, 1'b1, ALU_ADD, 1, 1, 0, 1'b0, 0);
      repeat (70000) @(posedge clk_i);
      #1;
      settle();
      n_checks++; if (stall_cycles_o !== 16'hFFFF) begin n_errors++; $display("FAIL sat_stall got=%h exp=ffff", stall_cycles_o); end
      step();
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      settle();
      n_checks++; if (stall_cycles_o !== 16'hFFFF) begin n_errors++; $display("FAIL sat_after_flush got=%h exp=ffff", stall_cycles_o); end
   endtask

   task automatic test_async_reset();
      do_reset();
      set_req(0, 1'b1, ALU_ADD, 2, 3, 0, 1'b0, 4'd6);
      set_req(1, 1'b1, ALU_JAL, 0, 0, 32'h40, 1'b0, 4'd8);
      repeat (4) step();
      #2 rst_n_i = 1'b0;
      #1;
      n_checks++; if (bus.res_valid_o !== 1'b0 || bus.res_result_o !== 32'd0 || bus.res_tag_o !== 4'd0) begin n_errors++; $display("FAIL arst_res got=v%b %h t%0d exp=v0 0 t0", bus.res_valid_o, bus.res_result_o, bus.res_tag_o); end
      n_checks++; if (bus.res_source_o !== 1'b0 || bus.res_is_branch_o !== 1'b0 || bus.res_branch_taken_o !== 1'b0) begin n_errors++; $display("FAIL arst_flags got=%b%b%b exp=000", bus.res_source_o, bus.res_is_branch_o, bus.res_branch_taken_o); end
      n_checks++; if (wait_redirect_o !== 1'b0 || stall_cycles_o !== 16'd0) begin n_errors++; $display("FAIL arst_wait_stall got=w%b s%0d exp=w0 s0", wait_redirect_o, stall_cycles_o); end
      #1 rst_n_i = 1'b1;
      #1;
      n_checks++; if (bus.req_ready_o !== 2'b01) begin n_errors++; $display("FAIL arst_first_grant got=%b exp=01", bus.req_ready_o); end
      step();
      settle();
      n_checks++; if (bus.res_valid_o !== 1'b1 || bus.res_source_o !== 1'b0 || bus.res_result_o !== 32'd5) begin n_errors++; $display("FAIL arst_first_result got=v%b s%b %0d exp=v1 s0 5", bus.res_valid_o, bus.res_source_o, bus.res_result_o); end
   endtask

   task automatic test_random();
      int g;
      int sel;
      logic [31:0] a;
      do_reset();
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int p = 0; p < 2; p++) begin
            a = $urandom_range(0, 3);
            set_req(p, ($urandom % 4) != 0, alu_operation_t'($urandom_range(0, 9)), a,
                    (($urandom % 2) == 0) ? a : $urandom, $urandom & 32'hFFFF_FFFE,
                    $urandom % 2, 4'($urandom));
         end
         bus.res_ready_i = ($urandom % 3) != 0;
         flush_i         = ($urandom % 16) == 0;
         redirect_ack_i  = ($urandom % 3) == 0;
         settle();
         g = model_grant();
         sel = (g >= 0) ? g : m_last;
         n_checks++; if (bus.req_ready_o !== (g < 0 ? 2'b00 : (g == 1 ? 2'b10 : 2'b01))) begin n_errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp_grant=%0d", cyc, bus.req_ready_o, g); end
         n_checks++; if (alu_data_valid_o !== (g >= 0)) begin n_errors++; $display("FAIL rnd_alu_valid cyc=%0d got=%b exp=%0d", cyc, alu_data_valid_o, g >= 0); end
         n_checks++; if (alu_operand_A_o !== bus.req_operand_A_i[sel] || alu_operation_o !== bus.req_operation_i[sel]) begin n_errors++; $display("FAIL rnd_alu_mux cyc=%0d got=%h exp_port=%0d", cyc, alu_operand_A_o, sel); end
         n_checks++; if (bus.res_valid_o !== m_rv) begin n_errors++; $display("FAIL rnd_res_valid cyc=%0d got=%b exp=%b", cyc, bus.res_valid_o, m_rv); end
         if (m_rv) begin
            n_checks++; if (bus.res_result_o !== m_res || bus.res_tag_o !== m_tag || bus.res_source_o !== m_src[0]) begin n_errors++; $display("FAIL rnd_res cyc=%0d got=%h t%0d s%b exp=%h t%0d s%0d", cyc, bus.res_result_o, bus.res_tag_o, bus.res_source_o, m_res, m_tag, m_src); end
            n_checks++; if (bus.res_is_branch_o !== m_br || bus.res_branch_taken_o !== m_tk) begin n_errors++; $display("FAIL rnd_branch cyc=%0d got=%b%b exp=%b%b", cyc, bus.res_is_branch_o, bus.res_branch_taken_o, m_br, m_tk); end
         end
         n_checks++; if (wait_redirect_o !== m_wait) begin n_errors++; $display("FAIL rnd_wait cyc=%0d got=%b exp=%b", cyc, wait_redirect_o, m_wait); end
         n_checks++; if (stall_cycles_o !== 16'(m_stall)) begin n_errors++; $display("FAIL rnd_stall cyc=%0d got=%0d exp=%0d", cyc, stall_cycles_o, m_stall); end
         @(posedge clk_i);
         model_update(g);
         #1;
      end
   endtask

   initial begin
      idle_all();
      test_reset();
      test_round_robin();
      test_hold();
      test_branch();
      test_flush();
      test_async_reset();
      test_random();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/alu_issue_scheduler.md
ALU_ISSUE_SCHEDULER -- requirements
Module: alu_issue_scheduler

Interface
REQ-001 SHALL have parameter XLEN, 32, datapath width (matches core XLEN).
REQ-002 SHALL have parameter TAG_W, 4, width of the per-request instruction tag.
REQ-003 SHALL have ports clk_i input 1, the single core clock, and rst_n_i input 1, reset, asynchronous and active-low.
REQ-004 SHALL have ports flush_i input 1, pipeline flush, and redirect_ack_i input 1, front end acknowledges a taken-branch redirect.
REQ-005 SHALL have request ports req_valid_i input 2 and req_ready_o output 2, one valid/ready pair per requester, index 0 and 1.
REQ-006 SHALL have request payload ports req_operand_A_i, req_operand_B_i and req_instr_addr_i, each input 2xXLEN.
REQ-007 SHALL have request payload ports req_operation_i input 2xalu_operation_t, req_is_compressed_i input 2, and req_tag_i input 2xTAG_W.
REQ-008 SHALL have ALU-side outputs alu_operand_A_o, alu_operand_B_o and alu_instr_addr_o (XLEN each), alu_operation_o (alu_operation_t), alu_is_compressed_jump_o (1) and alu_data_valid_o (1).
REQ-009 SHALL have ALU-side inputs alu_result_i (XLEN), alu_branch_taken_i (1), alu_is_branch_i (1) and alu_data_valid_i (1).
REQ-010 SHALL have result ports res_valid_o output 1, res_ready_i input 1, res_result_o output XLEN, res_tag_o output TAG_W, res_source_o output 1 (granted index), res_is_branch_o output 1 and res_branch_taken_o output 1.
REQ-011 SHALL have ports wait_redirect_o output 1, high in WAIT_REDIRECT, and stall_cycles_o output 16, contention counter.

Function
REQ-012 SHALL implement FSM states ISSUE and WAIT_REDIRECT.
REQ-013 SHALL set can_issue = state==ISSUE and !flush_i and (!res_valid_o or res_ready_i).
REQ-014 SHALL grant, when can_issue, the sole valid requester; if both are valid, it SHALL grant the index not equal to last_grant (round-robin).
REQ-015 SHALL assert req_ready_o only on the granted index, combinationally in the same cycle; accept = req_valid_i and req_ready_o on that index.
REQ-016 SHALL drive the ALU inputs combinationally from the granted payload; when there is no grant, it SHALL drive the index-last_grant payload with alu_data_valid_o=0, and alu_data_valid_o SHALL equal accept.
REQ-017 SHALL capture alu_result_i, alu_is_branch_i, alu_branch_taken_i, the tag and the source index into the result register on the accept edge; res_valid_o SHALL rise 1 cycle after acceptance.
REQ-018 SHALL update last_grant to the granted index only on accept.
REQ-019 SHALL clear res_valid_o when res_ready_i is high without accept; on simultaneous consume and accept, it SHALL load the new result and keep res_valid_o=1 (back-to-back, 1 op/cycle).
REQ-020 SHALL hold the result register stable while res_valid_o=1 and res_ready_i=0.
REQ-021 SHALL go ISSUE->WAIT_REDIRECT on the accept edge when alu_is_branch_i=1 and alu_branch_taken_i=1 (JAL, JALR, taken Bxx); no grants SHALL occur in WAIT_REDIRECT.
REQ-022 SHALL go WAIT_REDIRECT->ISSUE on the edge where redirect_ack_i=1; grants SHALL resume the following cycle, and redirect_ack_i SHALL be ignored in ISSUE.
REQ-023 SHALL, on flush_i=1, allow no grant in that cycle, clear res_valid_o on the next edge, and force state ISSUE; flush SHALL have priority over accept, consume and redirect_ack_i; last_grant SHALL be unchanged.
REQ-024 SHALL increment stall_cycles_o each cycle in which any req_valid_i is high and accept is 0; it SHALL saturate at 0xFFFF and SHALL not be cleared by flush.
REQ-025 SHALL not let alu_data_valid_i affect control; it is used only for assertion checking (must equal alu_data_valid_o).

Reset
REQ-026 SHALL, while rst_n_i=0, asynchronously force state=ISSUE, last_grant=1 (port 0 wins first), res_valid_o=0, res_result_o=0, res_tag_o=0, res_source_o=0, res_is_branch_o=0, res_branch_taken_o=0 and stall_cycles_o=0.
REQ-027 SHALL, when reset is asserted mid-operation, drop any in-flight result and pending redirect wait, and on release start granting in the first cycle.

Verification
REQ-028 SHALL be verified with: both ports valid continuously with ADD ops, res_ready_i=1 -> grants alternate 0,1,0,1, with one result per cycle starting 1 cycle after the first accept.
REQ-029 SHALL be verified with: port 0 ADD 5+7, res_ready_i=0 for 3 cycles -> res_result_o=12 held, port 1 request stalls, stall_cycles_o=3.
REQ-030 SHALL be verified with: port 1 BEQ with equal operands -> res_branch_taken_o=1, wait_redirect_o=1, no grants until redirect_ack_i, then a grant on the next cycle.
REQ-031 SHALL be verified with: flush_i pulsed while res_valid_o=1 and in WAIT_REDIRECT -> res_valid_o=0 and state=ISSUE after 1 edge, with no grant in the flush cycle.
REQ-032 SHALL be verified with: stall forced for 70000 cycles -> stall_cycles_o=0xFFFF held.
REQ-033 SHALL be verified with: rst_n_i low mid-stream asynchronously -> all outputs at reset values immediately; after release, port 0 is granted first when both ports are valid.
